// File: rtl/alu_seq.sv
// alu_seq: handshaked, registered ALU sitting between register-file read and writeback.
// Most ops complete in one cycle. MUL uses shift-add and DIVU uses restoring division.
// Each of these two iterative ops produces one result bit per cycle for WIDTH cycles.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake; in_ready is high only in IDLE
//   op, cin               operation code, carry/borrow in for ADD/SUB
//   alu_a, alu_b          source / destination operands
//   out_valid / out_ready result handshake; the result is held in HOLD until taken
//   alu_out, alu_out_hi   result low half, and the high half (MUL high, DIVU remainder)
//   c, z, v, s            carry/borrow, zero, overflow, sign of alu_out
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic             cin,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic [WIDTH-1:0] alu_out_hi,
    output logic             c,
    output logic             z,
    output logic             v,
    output logic             s
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SHL  = 4'b0101;
    localparam logic [3:0] OP_SHR  = 4'b0110;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_ROL  = 4'b1001;
    localparam logic [3:0] OP_ROR  = 4'b1010;
    localparam logic [3:0] OP_MUL  = 4'b1011;
    localparam logic [3:0] OP_DIVU = 4'b1100;

    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t           state;
    logic             is_mul;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] operand_r;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;

    // Single-cycle datapath, evaluated directly from the inputs presented in IDLE.
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH-1:0] rot_amt;
    logic             shift_big;
    logic             iterative;
    logic [WIDTH-1:0] sc_lo;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c;
    logic             sc_v;

    // The borrow is the top bit of a (WIDTH+1)-bit subtraction.
    // This sets c exactly when b < a + cin over the full operand range.
    assign add_sum   = {1'b0, alu_b} + {1'b0, alu_a} + {{WIDTH{1'b0}}, cin};
    assign sub_diff  = {1'b0, alu_b} - {1'b0, alu_a} - {{WIDTH{1'b0}}, cin};
    assign rot_amt   = alu_a % W_VAL;
    assign shift_big = (alu_a >= W_VAL);
    // Dividing by zero takes the single-cycle path instead of iterating.
    assign iterative = (op == OP_MUL) || ((op == OP_DIVU) && (alu_a != '0));

    always_comb begin
        sc_lo = '0;
        sc_hi = '0;
        sc_c  = 1'b0;
        sc_v  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_lo = add_sum[WIDTH-1:0];
                sc_c  = add_sum[WIDTH];
                sc_v  = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != alu_b[WIDTH-1]);
            end
            OP_SUB: begin
                sc_lo = sub_diff[WIDTH-1:0];
                sc_c  = sub_diff[WIDTH];
                sc_v  = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) &&
                        (sub_diff[WIDTH-1] != alu_b[WIDTH-1]);
            end
            OP_AND: sc_lo = alu_b & alu_a;
            OP_OR:  sc_lo = alu_b | alu_a;
            OP_XOR: sc_lo = alu_b ^ alu_a;
            OP_SHL: begin
                sc_lo = shift_big ? '0 : (alu_b << alu_a);
                sc_c  = alu_b[WIDTH-1];
            end
            OP_SHR: begin
                sc_lo = shift_big ? '0 : (alu_b >> alu_a);
                sc_c  = alu_b[0];
            end
            OP_NOT: sc_lo = ~alu_b;
            // A rotate count of zero makes the second term a full-width shift.
            // That term is then zero, so b passes through unchanged.
            OP_ROL: sc_lo = (alu_b << rot_amt) | (alu_b >> (W_VAL - rot_amt));
            OP_ROR: sc_lo = (alu_b >> rot_amt) | (alu_b << (W_VAL - rot_amt));
            OP_DIVU: begin
                sc_lo = '1;
                sc_hi = alu_b;
                sc_v  = 1'b1;
            end
            default: ;
        endcase
    end

    // One iteration step.
    // MUL: {work_hi, work_lo} shifts right while the multiplicand is conditionally added.
    // DIVU: work_hi is the partial remainder, and quotient bits shift into work_lo.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_sub;
    logic             div_ge;
    logic [WIDTH-1:0] next_hi;
    logic [WIDTH-1:0] next_lo;

    assign mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, operand_r} : '0);
    assign div_shift = {work_hi, work_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, operand_r});
    assign div_sub   = div_shift - {1'b0, operand_r};

    always_comb begin
        if (is_mul) begin
            next_hi = mul_sum[WIDTH:1];
            next_lo = {mul_sum[0], work_lo[WIDTH-1:1]};
        end else begin
            next_hi = div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
            next_lo = {work_lo[WIDTH-2:0], div_ge};
        end
    end

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            is_mul     <= 1'b0;
            cnt        <= '0;
            operand_r  <= '0;
            work_hi    <= '0;
            work_lo    <= '0;
            out_valid  <= 1'b0;
            alu_out    <= '0;
            alu_out_hi <= '0;
            c          <= 1'b0;
            z          <= 1'b0;
            v          <= 1'b0;
            s          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (iterative) begin
                            // MUL: work_lo holds the multiplier and operand_r the multiplicand.
                            // DIVU: work_lo holds the dividend and operand_r the divisor.
                            is_mul    <= (op == OP_MUL);
                            operand_r <= (op == OP_MUL) ? alu_b : alu_a;
                            work_lo   <= (op == OP_MUL) ? alu_a : alu_b;
                            work_hi   <= '0;
                            cnt       <= '0;
                            state     <= CALC;
                        end else begin
                            alu_out    <= sc_lo;
                            alu_out_hi <= sc_hi;
                            c          <= sc_c;
                            v          <= sc_v;
                            z          <= (sc_lo == '0);
                            s          <= sc_lo[WIDTH-1];
                            out_valid  <= 1'b1;
                            state      <= HOLD;
                        end
                    end
                end
                CALC: begin
                    work_hi <= next_hi;
                    work_lo <= next_lo;
                    cnt     <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        alu_out    <= next_lo;
                        alu_out_hi <= next_hi;
                        c          <= is_mul && (next_hi != '0);
                        v          <= is_mul && (next_hi != '0);
                        z          <= (next_lo == '0);
                        s          <= next_lo[WIDTH-1];
                        out_valid  <= 1'b1;
                        state      <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
